// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter with valid/ready input handshake.
// Each bit occupies Oversample clock cycles; the serial line is driven from a flop.
module uart_tx #(
    parameter int unsigned Oversample = 16
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = (Oversample > 1) ? $clog2(Oversample) : 1;
    localparam logic [CW-1:0] OS_M1 = CW'(Oversample - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] sampleCount_q, sampleCount_d;
    logic [3:0]    bitCount_q, bitCount_d;
    logic [7:0]    shift_q, shift_d;
    logic          out_q, out_d;

    logic sample_zero;
    logic accept;

    assign sample_zero = (sampleCount_q == '0);
    assign done        = (state_q == STOP) && sample_zero;
    assign ready       = (state_q == IDLE) || done;
    assign busy        = (state_q != IDLE);
    assign out         = out_q;
    assign accept      = valid && ready;

    always_comb begin
        state_d       = state_q;
        sampleCount_d = sample_zero ? sampleCount_q : sampleCount_q - CW'(1);
        bitCount_d    = bitCount_q;
        shift_d       = shift_q;

        case (state_q)
            IDLE: begin
                sampleCount_d = OS_M1;
                if (accept) begin
                    state_d = START;
                    shift_d = data;
                end
            end
            START: begin
                if (sample_zero) begin
                    state_d       = DATA;
                    sampleCount_d = OS_M1;
                    bitCount_d    = 4'd7;
                end
            end
            DATA: begin
                if (sample_zero) begin
                    sampleCount_d = OS_M1;
                    if (bitCount_q == 4'd0) begin
                        state_d = STOP;
                    end else begin
                        shift_d    = {1'b0, shift_q[7:1]};
                        bitCount_d = bitCount_q - 4'd1;
                    end
                end
            end
            STOP: begin
                if (sample_zero) begin
                    sampleCount_d = OS_M1;
                    // Accepting here chains the next frame with no idle gap.
                    if (accept) begin
                        state_d = START;
                        shift_d = data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                sampleCount_d = OS_M1;
            end
        endcase

        // Line level follows the next state so out_q lines up with the bit it represents.
        case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[0];
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q       <= IDLE;
            sampleCount_q <= OS_M1;
            bitCount_q    <= 4'd7;
            shift_q       <= '0;
            out_q         <= 1'b1;
        end else begin
            state_q       <= state_d;
            sampleCount_q <= sampleCount_d;
            bitCount_q    <= bitCount_d;
            shift_q       <= shift_d;
            out_q         <= out_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: two instances (Oversample 16 and 2) checked cycle by cycle,
// plus a behavioural serial receiver on the Oversample-16 line.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic [1:0] valid_v = '0;
    logic [7:0] data_v [2];
    logic [1:0] ready_v, out_v, busy_v, done_v;

    int total = 0;
    int bad = 0;

    logic [7:0] rxq [$];
    int         rxerr = 0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.Oversample(16)) dut16 (
        .clk(clk), .nReset(nReset), .data(data_v[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    uart_tx #(.Oversample(2)) dut2 (
        .clk(clk), .nReset(nReset), .data(data_v[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checks ncyc cycles of a frame whose accept edge just occurred.
    // mode 0: drop valid; mode 1: toggle valid and scribble data; mode 2: hold inputs.
    // On the final stop cycle the next handshake (nv/nd) is presented.
    task automatic run_frame(input int s, input logic [7:0] b, input int ncyc,
                             input int mode, input logic nv, input logic [7:0] nd);
        int o;
        int j;
        logic eo;
        o = (s == 1) ? 2 : 16;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            j = (k - 1) / o;
            eo = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
            chk("out",   {7'd0, out_v[s]},   {7'd0, eo});
            chk("busy",  {7'd0, busy_v[s]},  8'd1);
            chk("done",  {7'd0, done_v[s]},  {7'd0, k == 10*o});
            chk("ready", {7'd0, ready_v[s]}, {7'd0, k == 10*o});
            if (k == 10*o) begin
                valid_v[s] = nv;
                data_v[s]  = nd;
            end else if (mode == 1) begin
                valid_v[s] = k[0];
                data_v[s]  = 8'h3C;
            end else if (mode == 0) begin
                valid_v[s] = 1'b0;
            end
        end
    endtask

    task automatic idle_chk(input int s);
        @(negedge clk);
        chk("idle_out",   {7'd0, out_v[s]},   8'd1);
        chk("idle_busy",  {7'd0, busy_v[s]},  8'd0);
        chk("idle_ready", {7'd0, ready_v[s]}, 8'd1);
        chk("idle_done",  {7'd0, done_v[s]},  8'd0);
    endtask

    // Receiver model: mid-bit sampling, 16 cycles per bit.
    initial begin
        logic [7:0] rsh;
        forever begin
            @(negedge out_v[0]);
            if (mon_en) begin
                repeat (8) @(negedge clk);
                if (out_v[0] !== 1'b0) rxerr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    rsh[i] = out_v[0];
                end
                repeat (16) @(negedge clk);
                if (out_v[0] !== 1'b1) rxerr++;
                rxq.push_back(rsh);
            end
        end
    end

    initial begin
        logic [7:0] exp_rx [3];
        exp_rx[0] = 8'h55;
        exp_rx[1] = 8'h3C;
        exp_rx[2] = 8'hFF;
        data_v[0] = '0;
        data_v[1] = '0;

        repeat (3) @(negedge clk);
        chk("rst_out",   {7'd0, out_v[0]},   8'd1);
        chk("rst_ready", {7'd0, ready_v[0]}, 8'd1);
        chk("rst_busy",  {7'd0, busy_v[0]},  8'd0);
        chk("rst_done",  {7'd0, done_v[0]},  8'd0);
        nReset = 1'b1;
        idle_chk(0);
        idle_chk(1);

        // Single byte 0xA5
        valid_v[0] = 1'b1; data_v[0] = 8'hA5;
        run_frame(0, 8'hA5, 160, 0, 1'b0, 8'h00);
        idle_chk(0);

        // Back-to-back 0x00 then 0xFF with valid held
        valid_v[0] = 1'b1; data_v[0] = 8'h00;
        run_frame(0, 8'h00, 160, 2, 1'b1, 8'hFF);
        run_frame(0, 8'hFF, 160, 0, 1'b0, 8'h00);
        idle_chk(0);

        // Input activity during a 0x81 frame is ignored
        valid_v[0] = 1'b1; data_v[0] = 8'h81;
        run_frame(0, 8'h81, 160, 1, 1'b0, 8'h00);
        idle_chk(0);
        idle_chk(0);

        // Reset during data bit 3
        valid_v[0] = 1'b1; data_v[0] = 8'hA5;
        run_frame(0, 8'hA5, 69, 0, 1'b0, 8'h00);
        #2 nReset = 1'b0;
        #1;
        chk("mid_rst_out",   {7'd0, out_v[0]},   8'd1);
        chk("mid_rst_busy",  {7'd0, busy_v[0]},  8'd0);
        chk("mid_rst_ready", {7'd0, ready_v[0]}, 8'd1);
        chk("mid_rst_done",  {7'd0, done_v[0]},  8'd0);
        @(negedge clk);
        chk("mid_rst_done2", {7'd0, done_v[0]},  8'd0);
        nReset = 1'b1;
        idle_chk(0);
        valid_v[0] = 1'b1; data_v[0] = 8'h96;
        run_frame(0, 8'h96, 160, 0, 1'b0, 8'h00);
        idle_chk(0);

        // Loopback through receiver model
        mon_en = 1'b1;
        valid_v[0] = 1'b1; data_v[0] = 8'h55;
        run_frame(0, 8'h55, 160, 0, 1'b1, 8'h3C);
        run_frame(0, 8'h3C, 160, 0, 1'b1, 8'hFF);
        run_frame(0, 8'hFF, 160, 0, 1'b0, 8'h00);
        idle_chk(0);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        chk("rx_count", 8'(rxq.size()), 8'd3);
        chk("rx_errors", 8'(rxerr), 8'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rx_byte", (i < rxq.size()) ? rxq[i] : 8'hXX, exp_rx[i]);
        end

        // Minimum oversample, byte 0x01
        valid_v[1] = 1'b1; data_v[1] = 8'h01;
        run_frame(1, 8'h01, 20, 0, 1'b0, 8'h00);
        idle_chk(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
